// File: rtl/cpu_io_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_io_pkg : shared types and defaults for the CPU UART I/O blocks    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package cpu_io_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int c_clks_per_bit_def = 868;
  localparam int c_fifo_aw_def      = 9;

endpackage

`default_nettype wire

// File: rtl/uart_word_receiver_if.sv
// +----------------------------------------------------------------------+
// | uart_word_receiver_if : 32-bit word valid/ready handshake to the core |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface uart_word_receiver_if;

  logic        WORD_VALID;
  logic        WORD_READY;
  logic [31:0] WORD_DATA;

  modport master (
    output WORD_VALID,
    output WORD_DATA,
    input  WORD_READY
  );

  modport slave (
    input  WORD_VALID,
    input  WORD_DATA,
    output WORD_READY
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +----------------------------------------------------------------------+
// | uart_rx_core : 8N1 UART deserialiser with 2-flop input synchroniser   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_rx_core
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_def
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_frame_err
);

  localparam int              c_cw        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      r_sync;
  logic            w_rx;
  rx_state_t       r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_ferr, w_ferr_nxt;

  assign w_rx          = r_sync[1];
  assign rx_byte       = r_shift;
  assign rx_byte_valid = r_valid;
  assign rx_frame_err  = r_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) w_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-start re-check rejects short glitches on an idle line
        if (r_cnt == c_half_last) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = RX_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_word_receiver.sv
// +----------------------------------------------------------------------+
// | uart_word_receiver : UART bytes -> byte FIFO -> MSB-first 32-bit words |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_word_receiver
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_def,
  parameter int FIFO_AW      = c_fifo_aw_def
) (
  input  wire                        CLK,
  input  wire                        INITIALIZE_N,
  input  wire                        UART_RX,
  input  wire                        RX_ENABLE,
  input  wire                        FLUSH,
  uart_word_receiver_if.master       word_if,
  output logic [FIFO_AW-1:0]         FILL_LEVEL,
  output logic                       OVERFLOW,
  output logic                       FRAME_ERR
);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [7:0]         w_rx_byte;
  logic               w_rx_valid;
  logic               w_rx_ferr;

  logic [7:0]         r_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_inc;
  logic               w_empty, w_full, w_push, w_pop, w_drop, w_word_done;
  logic [7:0]         w_pop_byte;
  logic [23:0]        r_shreg;
  logic [1:0]         r_cnt;
  logic               r_word_valid;
  logic [31:0]        r_word_data;
  logic               r_overflow, r_frame_err;

  // Reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) r_rst_sync <= 2'b00;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk           (CLK),
    .rst_n         (w_rst_n),
    .rx            (UART_RX),
    .rx_byte       (w_rx_byte),
    .rx_byte_valid (w_rx_valid),
    .rx_frame_err  (w_rx_ferr)
  );

  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (w_wr_ptr_inc == r_rd_ptr);
  assign w_push       = w_rx_valid & RX_ENABLE & ~w_full & ~FLUSH;
  assign w_drop       = w_rx_valid & RX_ENABLE & w_full;
  assign w_pop        = ~w_empty & ~(r_word_valid & ~word_if.WORD_READY) & ~FLUSH;
  assign w_word_done  = w_pop & (r_cnt == 2'd3);
  assign w_pop_byte   = r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_byte;
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (FLUSH) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_shreg  <= {r_shreg[15:0], w_pop_byte};
        r_cnt    <= r_cnt + 2'd1;
      end
      // A word completing in the handshake cycle keeps VALID asserted
      if (w_word_done) begin
        r_word_valid <= 1'b1;
        r_word_data  <= {r_shreg, w_pop_byte};
      end else if (word_if.WORD_READY) begin
        r_word_valid <= 1'b0;
      end
      if (w_drop)    r_overflow  <= 1'b1;
      if (w_rx_ferr) r_frame_err <= 1'b1;
    end
  end

  assign word_if.WORD_VALID = r_word_valid;
  assign word_if.WORD_DATA  = r_word_data;
  assign FILL_LEVEL         = r_wr_ptr - r_rd_ptr;
  assign OVERFLOW           = r_overflow;
  assign FRAME_ERR          = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_receiver.sv
// +----------------------------------------------------------------------+
// | tb_uart_word_receiver : directed self-checking bench                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_word_receiver;

  localparam int CPB = 8;
  localparam int AW  = 9;

  logic          CLK          = 1'b0;
  logic          INITIALIZE_N = 1'b1;
  logic          UART_RX      = 1'b1;
  logic          RX_ENABLE    = 1'b0;
  logic          FLUSH        = 1'b0;
  logic [AW-1:0] FILL_LEVEL;
  logic          OVERFLOW;
  logic          FRAME_ERR;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got[$];

  uart_word_receiver_if word_if ();

  uart_word_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .CLK          (CLK),
    .INITIALIZE_N (INITIALIZE_N),
    .UART_RX      (UART_RX),
    .RX_ENABLE    (RX_ENABLE),
    .FLUSH        (FLUSH),
    .word_if      (word_if),
    .FILL_LEVEL   (FILL_LEVEL),
    .OVERFLOW     (OVERFLOW),
    .FRAME_ERR    (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Accepted words are recorded mid-cycle, where VALID and READY are settled
  always @(negedge CLK) begin
    if (word_if.WORD_VALID === 1'b1 && word_if.WORD_READY === 1'b1)
      got.push_back(word_if.WORD_DATA);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    UART_RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      tick(CPB);
    end
    UART_RX = stop_bit;
    tick(CPB);
    UART_RX = 1'b1;
  endtask

  initial begin
    word_if.WORD_READY = 1'b0;
    #1 INITIALIZE_N = 1'b0;
    tick(2);
    check("rst_valid", 32'(word_if.WORD_VALID), 32'd0);
    check("rst_data",  word_if.WORD_DATA,       32'd0);
    check("rst_fill",  32'(FILL_LEVEL),         32'd0);
    check("rst_ovf",   32'(OVERFLOW),           32'd0);
    check("rst_ferr",  32'(FRAME_ERR),          32'd0);
    INITIALIZE_N = 1'b1;
    tick(5);

    // Single word with the core always ready
    RX_ENABLE = 1'b1;
    word_if.WORD_READY = 1'b1;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    tick(10);
    check("w1_count", 32'(got.size()), 32'd1);
    check("w1_data",  got_at(0), 32'h1234_5678);
    check("w1_fill",  32'(FILL_LEVEL), 32'd0);
    check("w1_valid", 32'(word_if.WORD_VALID), 32'd0);

    // Backpressure: two words queued, released one accept at a time
    got.delete();
    word_if.WORD_READY = 1'b0;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h2A, 1'b1);
    tick(10);
    check("bp_valid", 32'(word_if.WORD_VALID), 32'd1);
    check("bp_data",  word_if.WORD_DATA, 32'hDEAD_BEEF);
    check("bp_fill",  32'(FILL_LEVEL), 32'd4);
    tick(20);
    check("bp_hold_data", word_if.WORD_DATA, 32'hDEAD_BEEF);
    check("bp_hold_fill", 32'(FILL_LEVEL), 32'd4);
    word_if.WORD_READY = 1'b1;
    tick(1);
    word_if.WORD_READY = 1'b0;
    tick(10);
    check("bp2_valid", 32'(word_if.WORD_VALID), 32'd1);
    check("bp2_data",  word_if.WORD_DATA, 32'h0000_002A);
    check("bp2_fill",  32'(FILL_LEVEL), 32'd0);
    word_if.WORD_READY = 1'b1;
    tick(1);
    word_if.WORD_READY = 1'b0;
    tick(2);
    check("bp_count", 32'(got.size()), 32'd2);
    check("bp_w0",    got_at(0), 32'hDEAD_BEEF);
    check("bp_w1",    got_at(1), 32'h0000_002A);
    check("bp_valid_clr", 32'(word_if.WORD_VALID), 32'd0);

    // Overflow: 4 bytes sit in the packer, 511 in the FIFO, rest dropped
    got.delete();
    for (int i = 0; i < 600; i++) send_byte(8'(i), 1'b1);
    tick(10);
    check("ov_fill",  32'(FILL_LEVEL), 32'd511);
    check("ov_flag",  32'(OVERFLOW), 32'd1);
    check("ov_valid", 32'(word_if.WORD_VALID), 32'd1);
    check("ov_data",  word_if.WORD_DATA, 32'h0001_0203);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    tick(1);
    check("fl_fill",  32'(FILL_LEVEL), 32'd0);
    check("fl_ovf",   32'(OVERFLOW), 32'd0);
    check("fl_valid", 32'(word_if.WORD_VALID), 32'd0);

    // Framing error, then clean bytes still assemble correctly
    word_if.WORD_READY = 1'b1;
    send_byte(8'h55, 1'b0);
    tick(2 * CPB);
    check("fe_flag", 32'(FRAME_ERR), 32'd1);
    check("fe_fill", 32'(FILL_LEVEL), 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    tick(10);
    check("fe_count", 32'(got.size()), 32'd1);
    check("fe_word",  got_at(0), 32'hA511_2233);
    check("fe_sticky", 32'(FRAME_ERR), 32'd1);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    tick(1);
    check("fe_clr", 32'(FRAME_ERR), 32'd0);

    // RX_ENABLE gating and glitch rejection
    got.delete();
    RX_ENABLE = 1'b0;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    tick(10);
    check("en_fill",  32'(FILL_LEVEL), 32'd0);
    check("en_count0", 32'(got.size()), 32'd0);
    RX_ENABLE = 1'b1;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    tick(10);
    check("en_count1", 32'(got.size()), 32'd1);
    check("en_word",   got_at(0), 32'h0102_0304);
    UART_RX = 1'b0;
    tick(2);
    UART_RX = 1'b1;
    tick(4 * CPB);
    check("gl_fill", 32'(FILL_LEVEL), 32'd0);
    check("gl_ferr", 32'(FRAME_ERR), 32'd0);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h0D, 1'b1);
    tick(10);
    check("gl_count", 32'(got.size()), 32'd2);
    check("gl_word",  got_at(1), 32'h0A0B_0C0D);

    // Reset mid-word (2 bytes packed) and mid-frame
    got.delete();
    send_byte(8'h91, 1'b1);
    send_byte(8'h92, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h94, 1'b1);
    send_byte(8'h95, 1'b1);
    send_byte(8'h96, 1'b1);
    send_byte(8'h00, 1'b0);
    tick(2 * CPB);
    check("pre_rst_ferr", 32'(FRAME_ERR), 32'd1);
    check("pre_rst_data", word_if.WORD_DATA, 32'h9192_9394);
    UART_RX = 1'b0;
    tick(CPB);
    UART_RX = 1'b1;
    tick(3 * CPB);
    INITIALIZE_N = 1'b0;
    #1;
    check("mid_rst_data",  word_if.WORD_DATA, 32'd0);
    check("mid_rst_valid", 32'(word_if.WORD_VALID), 32'd0);
    check("mid_rst_ferr",  32'(FRAME_ERR), 32'd0);
    check("mid_rst_fill",  32'(FILL_LEVEL), 32'd0);
    UART_RX = 1'b1;
    tick(2);
    INITIALIZE_N = 1'b1;
    tick(5);
    got.delete();
    send_byte(8'hC0, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hEE, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(10);
    check("post_rst_count", 32'(got.size()), 32'd1);
    check("post_rst_word",  got_at(0), 32'hC0FF_EE11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
